mod_mul_seq: RTL and testbench

MOD_MUL_SEQ -- requirements
Module: mod_mul_seq

---
 rtl/mod_mul_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_mod_mul_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mul_seq.sv
// ---------------------------------------------------------------------------
// mod_mul_seq
//
// Purpose:
//    Sequential modular multiplier that computes result = (x * y) mod n with
//    MSB-first interleaved modular multiplication. Every iteration doubles the
//    running accumulator and conditionally adds y. An external
//    adder/subtractor stage then brings the sum back below n. That stage
//    performs all arithmetic. This block only sequences it and keeps the
//    accumulator, the multiplier shift register and the iteration counter.
//
//    Each of the NUM_OF_BITS iterations takes two cycles:
//       ISSUE : drive the stage operands and pulse as_enable.
//       WAIT  : the stage outputs are now registered. Select the reduced sum
//               into acc.
//    For this reason a start accepted at edge E0 produces done in the cycle
//    after edge E0 + 2*NUM_OF_BITS, and the timing does not depend on the data.
//
// Parameters:
//    NUM_OF_BITS      operand, modulus and result width (W)
//
// Ports:
//    clk              single clock, rising edge
//    reset_n          asynchronous active-low reset
//    start            request a multiplication; taken only while ready=1
//    x, y, n          multiplier, multiplicand, modulus (sampled on accept)
//    ready            high only while idle
//    result           (x*y) mod n, held until a later result replaces it
//    done             one-cycle pulse marking result valid
//    as_A, as_B       stage addend operands (y and 2*acc)
//    as_N             stage modulus (latched n)
//    as_B_bit         stage add-enable for as_A (current multiplier bit)
//    as_carry_in      tied low
//    as_borrow_1_in   tied low
//    as_borrow_2_in   tied low
//    as_enable        stage load strobe, high only in ISSUE
//    as_reset_n       stage reset, follows reset_n combinationally
//    as_S0/S1/S2      registered stage results: sum, sum-n, sum-2n
//    as_carry_out     stage carry (always 0 for legal operands, ignored)
//    as_borrow_1_out  borrow of sum-n
//    as_borrow_2_out  borrow of sum-2n
// ---------------------------------------------------------------------------
module mod_mul_seq #(
   parameter int NUM_OF_BITS = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [NUM_OF_BITS-1:0] x,
   input  logic [NUM_OF_BITS-1:0] y,
   input  logic [NUM_OF_BITS-1:0] n,
   output logic                   ready,
   output logic [NUM_OF_BITS-1:0] result,
   output logic                   done,
   output logic [NUM_OF_BITS-1:0] as_A,
   output logic [NUM_OF_BITS-1:0] as_B,
   output logic [NUM_OF_BITS-1:0] as_N,
   output logic                   as_B_bit,
   output logic                   as_carry_in,
   output logic                   as_borrow_1_in,
   output logic                   as_borrow_2_in,
   output logic                   as_enable,
   output logic                   as_reset_n,
   input  logic [NUM_OF_BITS-1:0] as_S0,
   input  logic [NUM_OF_BITS-1:0] as_S1,
   input  logic [NUM_OF_BITS-1:0] as_S2,
   input  logic                   as_carry_out,
   input  logic                   as_borrow_1_out,
   input  logic                   as_borrow_2_out
);

   localparam int W     = NUM_OF_BITS;
   localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [W-1:0]     xs;
   logic [W-1:0]     y_reg;
   logic [W-1:0]     n_reg;
   logic [W-1:0]     acc;
   logic [W-1:0]     acc_sel;
   logic [CNT_W-1:0] cnt;
   logic             last_iter;

   // The carry out of the stage cannot be set while acc < n < 2^(W-2), so
   // nothing uses it. It is collected here so that no port is left dangling.
   logic             unused_carry;
   assign unused_carry = as_carry_out;

   // The stage reset follows the block reset directly. A reset asserted in
   // the middle of an operation therefore clears the stage registers at the
   // same moment as the FSM.
   assign as_reset_n = reset_n;

   // The carry and borrow inputs are constant. The modulus stays fixed for
   // the whole operation, so the latched copy is always driven to the stage.
   assign as_carry_in    = 1'b0;
   assign as_borrow_1_in = 1'b0;
   assign as_borrow_2_in = 1'b0;
   assign as_N           = n_reg;

   // The operands go to the stage in every state, although the stage only
   // loads them in ISSUE. as_B is the accumulator doubled. The top bit of
   // acc is always 0 for legal operands, so dropping it loses nothing.
   assign as_A     = y_reg;
   assign as_B     = {acc[W-2:0], 1'b0};
   assign as_B_bit = xs[W-1];

   // The stage offers sum, sum-n and sum-2n. The largest of these that did
   // not borrow is the reduced value, because the sum is always below 3n.
   always_comb begin
      acc_sel = as_S0;
      if (!as_borrow_2_out) begin
         acc_sel = as_S2;
      end else if (!as_borrow_1_out) begin
         acc_sel = as_S1;
      end
   end

   assign last_iter = (cnt == '0);

   // State register. Reset forces IDLE immediately, so ready rises without
   // waiting for a clock and any operation in progress is abandoned.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A start is looked at only in IDLE. A start raised in
   // any other state is dropped and is not remembered for later.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            state_next = WAIT;
         end
         WAIT: begin
            if (last_iter) begin
               state_next = DONE;
            end else begin
               state_next = ISSUE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output decode. All three outputs come straight from the state, so the
   // done pulse is exactly one cycle long and lines up with the result.
   always_comb begin
      ready     = 1'b0;
      done      = 1'b0;
      as_enable = 1'b0;
      case (state)
         IDLE:    ready     = 1'b1;
         ISSUE:   as_enable = 1'b1;
         WAIT:    ;
         DONE:    done      = 1'b1;
         default: ;
      endcase
   end

   // Datapath registers.
   // On accept, the operands are captured and acc and cnt start fresh.
   // In WAIT, the reduced sum is stored in acc and the next multiplier bit
   // moves into xs[W-1]. On the last WAIT, the same reduced sum also goes
   // into result, so result is already valid during the DONE cycle.
   // Result is not cleared on a new accept. It keeps the previous answer
   // until the next answer overwrites it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         xs     <= '0;
         y_reg  <= '0;
         n_reg  <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  xs    <= x;
                  y_reg <= y;
                  n_reg <= n;
                  acc   <= '0;
                  cnt   <= CNT_W'(W - 1);
               end
            end
            WAIT: begin
               acc <= acc_sel;
               xs  <= {xs[W-2:0], 1'b0};
               if (last_iter) begin
                  result <= acc_sel;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_mod_mul_seq
//
// Bench for mod_mul_seq with W = 8.
//
// The bench contains a behavioural model of the downstream adder/subtractor
// stage. It forms B + (B_bit ? A : 0) + carry_in and registers three values
// together with their borrows: that sum, the sum minus N and the sum minus 2N.
//
// Expected results are plain (x*y) % n. The driver pushes each expected
// result into a queue when it issues a start. A monitor on the falling edge
// pops an entry on every done pulse and compares both the result and the
// latency.
// ---------------------------------------------------------------------------
module tb_mod_mul_seq;

   localparam int W       = 8;
   localparam int MAX_CYC = 200;

   logic         clk;
   logic         reset_n;
   logic         start;
   logic [W-1:0] x, y, n;
   logic         ready;
   logic [W-1:0] result;
   logic         done;
   logic [W-1:0] as_A, as_B, as_N;
   logic         as_B_bit, as_carry_in, as_borrow_1_in, as_borrow_2_in;
   logic         as_enable, as_reset_n;
   logic [W-1:0] as_S0, as_S1, as_S2;
   logic         as_carry_out, as_borrow_1_out, as_borrow_2_out;

   typedef struct {
      int n;
      int y;
      int res;
      int acc_cyc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp      = 0;
   int   n_fail     = 0;
   int   cyc        = 0;
   int   done_count = 0;
   bit   prev_done  = 1'b0;
   bit   prev_en    = 1'b0;
   bit [2:0] branch_seen = 3'b000;

   mod_mul_seq #(.NUM_OF_BITS(W)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .x               (x),
      .y               (y),
      .n               (n),
      .ready           (ready),
      .result          (result),
      .done            (done),
      .as_A            (as_A),
      .as_B            (as_B),
      .as_N            (as_N),
      .as_B_bit        (as_B_bit),
      .as_carry_in     (as_carry_in),
      .as_borrow_1_in  (as_borrow_1_in),
      .as_borrow_2_in  (as_borrow_2_in),
      .as_enable       (as_enable),
      .as_reset_n      (as_reset_n),
      .as_S0           (as_S0),
      .as_S1           (as_S1),
      .as_S2           (as_S2),
      .as_carry_out    (as_carry_out),
      .as_borrow_1_out (as_borrow_1_out),
      .as_borrow_2_out (as_borrow_2_out)
   );

   // Free-running clock and a cycle counter used for latency measurement.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural adder/subtractor stage. The arithmetic is done wide enough
   // that the top bit of each difference is the borrow.
   logic [W+2:0] st_sum, st_d1, st_d2;

   always_comb begin
      st_sum = {3'b000, as_B} + (as_B_bit ? {3'b000, as_A} : '0)
               + {{(W+2){1'b0}}, as_carry_in};
      st_d1  = st_sum - {3'b000, as_N} - {{(W+2){1'b0}}, as_borrow_1_in};
      st_d2  = st_sum - ({3'b000, as_N} << 1) - {{(W+2){1'b0}}, as_borrow_2_in};
   end

   always_ff @(posedge clk or negedge as_reset_n) begin
      if (!as_reset_n) begin
         as_S0           <= '0;
         as_S1           <= '0;
         as_S2           <= '0;
         as_carry_out    <= 1'b0;
         as_borrow_1_out <= 1'b0;
         as_borrow_2_out <= 1'b0;
      end else if (as_enable) begin
         as_S0           <= st_sum[W-1:0];
         as_carry_out    <= st_sum[W];
         as_S1           <= st_d1[W-1:0];
         as_borrow_1_out <= st_d1[W+2];
         as_S2           <= st_d2[W-1:0];
         as_borrow_2_out <= st_d2[W+2];
      end
   end

   // Single comparison point. Every check in the bench goes through here.
   task automatic checkOutput(input string name, input longint act, input longint req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor. On every done pulse it pops the oldest expected entry and
   // compares result and latency. It also checks the stage operands whenever
   // the stage is enabled, and notes which reduction the stage offered in
   // each WAIT cycle.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n) begin
         if (prev_done) checkOutput("done_pulse_width", done, 0);
         if (done) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("[TB] FAIL unexpected_done: got done=1 with result %0d, expected no done", result);
            end else begin
               e = sb.pop_front();
               checkOutput("result", result, e.res);
               checkOutput("latency", cyc - e.acc_cyc, 2 * W);
            end
            done_count++;
         end
         if (as_enable && sb.size() > 0) begin
            checkOutput("as_N", as_N, sb[0].n);
            checkOutput("as_A", as_A, sb[0].y);
            checkOutput("as_in_ties", {as_carry_in, as_borrow_1_in, as_borrow_2_in}, 0);
         end
         if (prev_en) begin
            if (!as_borrow_2_out)      branch_seen[2] = 1'b1;
            else if (!as_borrow_1_out) branch_seen[1] = 1'b1;
            else                       branch_seen[0] = 1'b1;
         end
      end
      prev_done = done;
      prev_en   = as_enable;
   end

   // Wait (bounded) for ready, then present one start for a single cycle and
   // record the expected result. The task is entered and left on a falling
   // edge.
   task automatic applyStimulus(input int xv, input int yv, input int nv);
      exp_t e;
      int   t = 0;
      while (!ready && t < MAX_CYC) begin
         @(negedge clk);
         t++;
      end
      checkOutput("ready_before_start", ready, 1);
      start = 1'b1;
      x     = W'(xv);
      y     = W'(yv);
      n     = W'(nv);
      e.n       = nv;
      e.y       = yv;
      e.res     = (xv * yv) % nv;
      e.acc_cyc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) until done is observed. The task returns on the falling
   // edge inside the DONE cycle.
   task automatic waitDone(input string name);
      int  t = 0;
      bit  seen = 1'b0;
      while (!seen && t < MAX_CYC) begin
         @(negedge clk);
         t++;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL %s_timeout: got no done within %0d cycles, expected done", name, MAX_CYC);
      end
   endtask

   // Safety net in case something stalls beyond every local bound.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int nv, xv, yv, dc0;
      reset_n = 1'b1;
      start   = 1'b0;
      x       = '0;
      y       = '0;
      n       = '0;

      // Reset state, observed while reset is still held.
      #2 reset_n = 1'b0;
      #1;
      checkOutput("rst_ready", ready, 1);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_result", result, 0);
      checkOutput("rst_as_enable", as_enable, 0);
      checkOutput("rst_as_reset_n", as_reset_n, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Directed cases.
      applyStimulus(3, 5, 7);
      waitDone("d_3_5_7");
      applyStimulus(0, 6, 7);
      waitDone("d_0_6_7");
      applyStimulus(1, 6, 7);
      waitDone("d_1_6_7");

      // All three reduction choices are needed for 60*60 mod 61.
      branch_seen = 3'b000;
      applyStimulus(60, 60, 61);
      waitDone("d_60_60_61");
      checkOutput("branches_exercised", branch_seen, 3'b111);

      // Range boundaries: smallest modulus, largest legal modulus.
      applyStimulus(0, 0, 1);
      waitDone("d_n1");
      applyStimulus(62, 62, 63);
      waitDone("d_n63");

      // Starts raised while busy carry junk operands. They must be ignored.
      applyStimulus(3, 5, 7);
      dc0 = done_count;
      for (int i = 0; i < MAX_CYC && !ready; i++) begin
         start = 1'b1;
         x     = W'($urandom);
         y     = W'($urandom);
         n     = W'($urandom_range(63, 1));
         @(negedge clk);
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("busy_start_not_queued_ready", ready, 1);
      checkOutput("busy_start_single_done", done_count - dc0, 1);

      // Reset during iteration 4. The ISSUE cycle of iteration k falls
      // 2k-1 cycles after the accept.
      applyStimulus(3, 5, 7);
      repeat (6) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("abort_ready", ready, 1);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_result", result, 0);
      checkOutput("abort_as_enable", as_enable, 0);
      sb.delete();
      dc0 = done_count;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("abort_no_done", done_count - dc0, 0);
      applyStimulus(3, 5, 7);
      waitDone("rerun_after_abort");

      // Back-to-back: the second start is presented in the idle cycle
      // directly after done. The first result must stay visible.
      applyStimulus(4, 5, 7);
      waitDone("b2b_first");
      @(negedge clk);
      checkOutput("b2b_ready_after_done", ready, 1);
      checkOutput("b2b_hold_before_accept", result, 6);
      applyStimulus(6, 6, 7);
      checkOutput("b2b_hold_after_accept", result, 6);
      waitDone("b2b_second");

      // Randomised legal operands.
      for (int i = 0; i < 20; i++) begin
         nv = $urandom_range(63, 1);
         xv = $urandom_range(nv - 1, 0);
         yv = $urandom_range(nv - 1, 0);
         applyStimulus(xv, yv, nv);
         waitDone("random");
      end

      repeat (4) @(negedge clk);
      checkOutput("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
